// File: rtl/mat_tx_scheduler.sv
// Round-robin dump scheduler: streams one of two matrix memories, element by element in
// row-major order, into a UART transmitter using a read/load/handshake sequence per byte.
module mat_tx_scheduler #(
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 2
) (
  input  logic       bclk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       rd_en,
  output logic       rd_sel,
  output logic [5:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       tx_ready,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       done
);

  localparam int unsigned NumElems = ROWS * COLS;
  localparam logic [5:0]  LastIdx  = 6'(NumElems - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoad,
    StWaitStart,
    StWaitEnd,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       rd_sel_q, rd_sel_d;
  logic [5:0] rd_addr_q, rd_addr_d;
  logic [5:0] idx_q, idx_d;
  logic       tx_ready_q, tx_ready_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       rr_q, rr_d;
  logic       winner;

  // A sole requester wins outright; on contention the round-robin pointer decides.
  always_comb begin
    winner = (req == 2'b11) ? rr_q : req[1];
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rd_sel_d   = rd_sel_q;
    rd_addr_d  = rd_addr_q;
    idx_d      = idx_q;
    tx_ready_d = 1'b0;
    tx_data_d  = tx_data_q;
    rr_d       = rr_q;
    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          grant_d   = winner ? 2'b10 : 2'b01;
          rd_sel_d  = winner;
          idx_d     = 6'd0;
          rd_addr_d = 6'd0;
          state_d   = StRead;
        end
      end
      StRead: begin
        state_d = StLoad;
      end
      StLoad: begin
        // rd_data is valid now, one cycle after the read strobe.
        tx_data_d  = rd_data;
        tx_ready_d = 1'b1;
        state_d    = StWaitStart;
      end
      StWaitStart: begin
        if (tx_busy) begin
          state_d = StWaitEnd;
        end
      end
      StWaitEnd: begin
        if (!tx_busy) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d     = idx_q + 6'd1;
            rd_addr_d = idx_q + 6'd1;
            state_d   = StRead;
          end
        end
      end
      StDone: begin
        rr_d    = ~rd_sel_q;
        grant_d = 2'b00;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= 2'b00;
      rd_sel_q   <= 1'b0;
      rd_addr_q  <= 6'd0;
      idx_q      <= 6'd0;
      tx_ready_q <= 1'b0;
      tx_data_q  <= 8'hFF;
      rr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rd_sel_q   <= rd_sel_d;
      rd_addr_q  <= rd_addr_d;
      idx_q      <= idx_d;
      tx_ready_q <= tx_ready_d;
      tx_data_q  <= tx_data_d;
      rr_q       <= rr_d;
    end
  end

  assign grant    = grant_q;
  assign rd_en    = (state_q == StRead);
  assign rd_sel   = rd_sel_q;
  assign rd_addr  = rd_addr_q;
  assign tx_ready = tx_ready_q;
  assign tx_data  = tx_data_q;
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_mat_tx_scheduler.sv
// Bench for mat_tx_scheduler: directed dump table, mid-frame reset, 1x1 boundary instance
// and randomized dumps checked against a round-robin reference model.
module tb_mat_tx_scheduler;

  localparam int NBytes = 4;

  logic       bclk = 1'b0;
  logic       rst  = 1'b0;
  logic [1:0] req  = 2'b00;
  logic [1:0] grant;
  logic       rd_en, rd_sel, tx_ready, tx_busy, done;
  logic [5:0] rd_addr;
  logic [7:0] rd_data, tx_data;

  logic [1:0] req1     = 2'b00;
  logic       tx_busy1 = 1'b0;
  logic [1:0] grant1;
  logic       rd_en1, rd_sel1, tx_ready1, done1;
  logic [5:0] rd_addr1;
  logic [7:0] rd_data1, tx_data1;

  logic [7:0] mem [2][64];
  int         busy_dly = 0;
  int         busy_len = 2;
  int         errors = 0;
  int         checks = 0;
  int         overlap = 0;
  logic       rr_m = 1'b0;

  always #5 bclk = ~bclk;

  mat_tx_scheduler #(.ROWS(2), .COLS(2)) u_dut (
    .bclk(bclk), .rst(rst), .req(req), .grant(grant), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_busy(tx_busy), .done(done)
  );

  mat_tx_scheduler #(.ROWS(1), .COLS(1)) u_one (
    .bclk(bclk), .rst(rst), .req(req1), .grant(grant1), .rd_en(rd_en1), .rd_sel(rd_sel1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .tx_ready(tx_ready1), .tx_data(tx_data1),
    .tx_busy(tx_busy1), .done(done1)
  );

  // Synchronous memories: data one cycle after the strobe, garbage otherwise.
  always @(posedge bclk) begin
    rd_data  <= rd_en ? mem[rd_sel][rd_addr] : 8'($urandom);
    rd_data1 <= rd_en1 ? 8'hA5 : 8'($urandom);
  end

  // Transmitter model: busy rises busy_dly cycles after tx_ready and lasts busy_len cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge bclk);
      #1;
      if (tx_ready) begin
        repeat (busy_dly) begin @(posedge bclk); #1; end
        tx_busy = 1'b1;
        repeat (busy_len) begin @(posedge bclk); #1; end
        tx_busy = 1'b0;
      end
    end
  end

  always @(negedge bclk) begin
    if ((rd_en && tx_ready) || (rd_en1 && tx_ready1)) overlap++;
  end

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, " grant"}, 32'(grant), 32'd0);
    chk({tag, " rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, " rd_sel"}, 32'(rd_sel), 32'd0);
    chk({tag, " rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, " tx_ready"}, 32'(tx_ready), 32'd0);
    chk({tag, " tx_data"}, 32'(tx_data), 32'hFF);
    chk({tag, " done"}, 32'(done), 32'd0);
  endtask

  // Follows one full dump from the idle cycle before grant to the idle cycle after done.
  // noise: 0 = leave req alone, 1 = drop req after byte 2, 2 = random req every byte.
  task automatic run_dump(input logic [1:0] eg, input int noise);
    int         k;
    int         fall;
    bit         saw_busy, stable, hit;
    logic [7:0] held;
    int         w;
    w = eg[1] ? 1 : 0;
    k = 0;
    while (grant == 2'b00 && k < 50) begin @(negedge bclk); k++; end
    chk("grant", 32'(grant), 32'(eg));
    chk("rd_sel", 32'(rd_sel), 32'(w));
    for (int i = 0; i < NBytes; i++) begin
      chk("rd_en", 32'(rd_en), 32'd1);
      chk("rd_addr", 32'(rd_addr), 32'(i));
      @(negedge bclk);
      chk("load cycle quiet", 32'({rd_en, tx_ready}), 32'd0);
      @(negedge bclk);
      chk("tx_ready", 32'(tx_ready), 32'd1);
      chk("tx_data", 32'(tx_data), 32'(mem[w][i]));
      chk("grant held", 32'(grant), 32'(eg));
      if (noise == 1 && i == 1) req = 2'b00;
      if (noise == 2) req = 2'($urandom);
      held     = tx_data;
      saw_busy = tx_busy;
      fall     = -1;
      stable   = 1'b1;
      hit      = 1'b0;
      k        = 0;
      while (!hit && k < 200) begin
        @(negedge bclk);
        k++;
        if (tx_data !== held) stable = 1'b0;
        if (tx_busy) saw_busy = 1'b1;
        else if (saw_busy && fall < 0) fall = k;
        hit = rd_en | done | tx_ready;
      end
      chk("tx_data stable", 32'(stable), 32'd1);
      chk("busy fall to next step", 32'(k - fall), 32'd1);
      chk("next step", 32'({rd_en, done, tx_ready}), (i == NBytes - 1) ? 32'd2 : 32'd4);
      if (!hit) return;
    end
    chk("rd_sel at done", 32'(rd_sel), 32'(w));
    @(negedge bclk);
    chk("done single pulse", 32'(done), 32'd0);
    chk("grant idle", 32'(grant), 32'd0);
  endtask

  typedef struct {
    logic [1:0] req;
    int         dly;
    int         len;
    int         noise;
    logic [1:0] exp_grant;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int         n_rd, n_tx, n_dn, fall_at, done_at, bcnt, k;
    logic [7:0] d1;
    logic [1:0] r, eg;
    logic       wm;

    vecs[0] = '{req: 2'b11, dly: 0, len: 2, noise: 0, exp_grant: 2'b01};
    vecs[1] = '{req: 2'b11, dly: 1, len: 3, noise: 0, exp_grant: 2'b10};
    vecs[2] = '{req: 2'b01, dly: 5, len: 2, noise: 0, exp_grant: 2'b01};
    vecs[3] = '{req: 2'b01, dly: 0, len: 4, noise: 1, exp_grant: 2'b01};
    vecs[4] = '{req: 2'b11, dly: 2, len: 1, noise: 2, exp_grant: 2'b10};
    vecs[5] = '{req: 2'b10, dly: 0, len: 2, noise: 0, exp_grant: 2'b10};
    vecs[6] = '{req: 2'b11, dly: 1, len: 2, noise: 0, exp_grant: 2'b01};
    mem[0][0] = 8'h11; mem[0][1] = 8'h22; mem[0][2] = 8'h33; mem[0][3] = 8'h44;
    mem[1][0] = 8'h55; mem[1][1] = 8'h66; mem[1][2] = 8'h77; mem[1][3] = 8'h88;

    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge bclk);
    rst = 1'b0;

    // 1x1 matrix: one read, one byte, done right after the first busy fall.
    n_rd = 0; n_tx = 0; n_dn = 0; fall_at = -10; done_at = -1; bcnt = 0; d1 = 8'h00;
    req1 = 2'b01;
    for (int c = 0; c < 40; c++) begin
      @(negedge bclk);
      if (rd_en1) n_rd++;
      if (done1) begin
        n_dn++;
        if (done_at < 0) done_at = c;
      end
      if (tx_ready1) begin
        n_tx++;
        d1       = tx_data1;
        req1     = 2'b00;
        tx_busy1 = 1'b1;
        bcnt     = 3;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) begin
          tx_busy1 = 1'b0;
          fall_at  = c;
        end
      end
    end
    chk("1x1 rd_en count", 32'(n_rd), 32'd1);
    chk("1x1 tx_ready count", 32'(n_tx), 32'd1);
    chk("1x1 done count", 32'(n_dn), 32'd1);
    chk("1x1 tx_data", 32'(d1), 32'hA5);
    chk("1x1 done after fall", 32'(done_at - fall_at), 32'd1);

    req = vecs[0].req;
    for (int v = 0; v < 7; v++) begin
      busy_dly = vecs[v].dly;
      busy_len = vecs[v].len;
      req      = vecs[v].req;
      run_dump(vecs[v].exp_grant, vecs[v].noise);
    end
    req = 2'b00;

    // Reset while byte 3 of a memory1 dump is in flight.
    busy_dly = 0;
    busy_len = 8;
    req      = 2'b10;
    n_tx     = 0;
    k        = 0;
    while (n_tx < 3 && k < 200) begin
      @(negedge bclk);
      k++;
      if (tx_ready) n_tx++;
    end
    chk("reached byte 3", 32'(n_tx), 32'd3);
    k = 0;
    while (!tx_busy && k < 50) begin @(negedge bclk); k++; end
    @(negedge bclk);
    chk("pre-reset rd_sel", 32'(rd_sel), 32'd1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("mid-frame reset");
    req = 2'b00;
    repeat (12) @(negedge bclk);
    check_reset_outputs("held reset");
    rst      = 1'b0;
    busy_len = 2;
    req      = 2'b10;
    run_dump(2'b10, 0);
    rr_m = 1'b0;

    // Randomized dumps against the round-robin reference model.
    for (int t = 0; t < 12; t++) begin
      for (int m = 0; m < 2; m++) begin
        for (int a = 0; a < NBytes; a++) mem[m][a] = 8'($urandom);
      end
      busy_dly = $urandom_range(0, 3);
      busy_len = $urandom_range(1, 5);
      r        = 2'($urandom_range(1, 3));
      wm       = (r == 2'b11) ? rr_m : (r == 2'b10);
      eg       = wm ? 2'b10 : 2'b01;
      rr_m     = ~wm;
      req      = r;
      run_dump(eg, 2);
    end

    // Round-robin pointer must return to memory0 on reset.
    req = 2'b01;
    run_dump(2'b01, 0);
    req = 2'b00;
    @(negedge bclk);
    rst = 1'b1;
    @(negedge bclk);
    rst = 1'b0;
    req = 2'b11;
    run_dump(2'b01, 0);
    req = 2'b00;

    repeat (3) @(negedge bclk);
    chk("rd_en/tx_ready overlap", 32'(overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mat_tx_scheduler.md
MAT_TX_SCHEDULER -- requirements
Module: mat_tx_scheduler

Interface
REQ-001 SHALL have parameter ROWS, default 2, matrix row count.
REQ-002 SHALL have parameter COLS, default 2, matrix column count; ROWS*COLS SHALL be in the range 1..64.
REQ-003 SHALL have port bclk, input, 1, baud clock; all logic SHALL be clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; reset is asynchronous, active-high.
REQ-005 SHALL have port req, input, 2, level-sensitive dump request per matrix memory (bit0 = memory 0, bit1 = memory 1).
REQ-006 SHALL have port grant, output, 2, one-hot owner of the transmitter; 00 when idle.
REQ-007 SHALL have port rd_en, output, 1, single-cycle memory read strobe.
REQ-008 SHALL have port rd_sel, output, 1, index of the memory being read; equals the granted requester.
REQ-009 SHALL have port rd_addr, output, 6, element address, row-major.
REQ-010 SHALL have port rd_data, input, 8, data from the selected memory, valid one bclk after rd_en.
REQ-011 SHALL have port tx_ready, output, 1, single-cycle transmit-start strobe to the UART transmitter.
REQ-012 SHALL have port tx_data, output, 8, registered byte to transmit; stable from tx_ready until tx_busy falls.
REQ-013 SHALL have port tx_busy, input, 1, transmitter status; high while a frame is in flight.
REQ-014 SHALL have port done, output, 1, single-cycle pulse when a full matrix dump completes.

Function
REQ-015 SHALL implement the states IDLE, READ, LOAD, WAIT_START, WAIT_END, and DONE.
REQ-016 IDLE: if any req bit is high, SHALL grant per a round-robin pointer rr (a 1-bit preferred requester), clear the element index idx, and go to READ; otherwise SHALL stay in IDLE.
REQ-017 Arbitration: a sole requester SHALL win; with both bits high, requester rr SHALL win.
REQ-018 The grant SHALL be latched for the whole dump; req changes during a dump SHALL be ignored, and a deasserted req SHALL NOT abort the dump.
REQ-019 READ: SHALL drive rd_en=1 and rd_addr=idx for exactly one cycle, then go to LOAD.
REQ-020 LOAD: SHALL register rd_data into tx_data, pulse tx_ready for one cycle, and go to WAIT_START.
REQ-021 WAIT_START: SHALL wait for tx_busy=1, then go to WAIT_END; there is no timeout.
REQ-022 WAIT_END: when tx_busy=0, SHALL go to DONE if idx==ROWS*COLS-1, otherwise SHALL increment idx and go to READ.
REQ-023 DONE: SHALL pulse done for one cycle, set rr to the requester that was not just served, clear grant, and go to IDLE.
REQ-024 Latency: tx_ready SHALL occur 2 bclk after leaving IDLE (READ, then LOAD).
REQ-025 Each subsequent byte's tx_ready SHALL occur 2 bclk after tx_busy falls.
REQ-026 Exactly ROWS*COLS bytes SHALL be sent per grant, at addresses 0..ROWS*COLS-1 in order; idx SHALL be 6 bits and SHALL NOT wrap within a dump.
REQ-027 Back-to-back dumps: a req still high in IDLE SHALL start a new dump immediately, subject to round-robin.
REQ-028 rd_en and tx_ready SHALL never be asserted in the same cycle.
REQ-029 rd_sel and rd_addr SHALL hold their last values outside READ.

Reset
REQ-030 rst=1 SHALL at any time (including mid-frame) force IDLE, grant=00, rd_en=0, rd_sel=0, rd_addr=0, tx_ready=0, tx_data=8'hFF, done=0, idx=0, rr=0.
REQ-031 After rst deasserts, SHALL require one bclk in IDLE before any grant.

Verification
REQ-032 Single dump: memory0 = {8'h11,8'h22,8'h33,8'h44}, pulse req=01 -> tx bytes 11,22,33,44 in order; done pulses once; grant=01 throughout the dump.
REQ-033 Contention: req=11 held after reset -> memory0 dumped first, then memory1 (rr toggles to 1); 8 bytes total; two done pulses.
REQ-034 Slow transmitter: tx_busy rises 5 cycles after tx_ready -> FSM holds in WAIT_START; no extra rd_en; tx_data is unchanged.
REQ-035 Mid-dump req drop: req0 falls after byte 2 -> all 4 bytes still sent; done=1 once.
REQ-036 Reset mid-frame: rst asserted during WAIT_END of byte 3 -> all outputs reach reset values immediately; after release, req=10 -> memory1 dump starts at rd_addr=0.
REQ-037 Boundary: ROWS=COLS=1 -> one rd_en, one tx_ready, and done follows the first tx_busy fall.
